// File: rtl/nn_loader_pkg.sv
// Shared types and sizes for the nn_input_loader slice.
package nn_loader_pkg;
    localparam int DW  = 5;
    localparam int N_X = 4;
    localparam int N_W = 28;

    typedef logic signed [DW-1:0] word_t;

    typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_X, ISSUE, WAIT} state_t;
endpackage

// File: rtl/nn_frame_shift.sv
// Counted shadow register: words land at shadow[cnt], commit copies the frame
// (including the word written on the same edge) to the output bus.
module nn_frame_shift
    import nn_loader_pkg::*;
#(
    parameter int DEPTH = N_W,
    parameter int CW    = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  word_t                       wr_data,
    input  logic                        clr,
    input  logic                        commit,
    output logic                        at_last,
    output logic [DEPTH-1:0][DW-1:0]    bus
);
    logic [CW-1:0]              cnt;
    logic [DEPTH-1:0][DW-1:0]   shadow, shadow_nxt;

    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        assign shadow_nxt[i] = (wr_en && cnt == CW'(i)) ? wr_data : shadow[i];
    end

    assign at_last = (cnt == CW'(DEPTH-1));

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
            bus    <= '0;
            cnt    <= '0;
        end else begin
            shadow <= shadow_nxt;
            if (clr)        cnt <= '0;
            else if (wr_en) cnt <= cnt + 1'b1;
            if (commit)     bus <= shadow_nxt;
        end
    end
endmodule

// File: rtl/nn_input_loader.sv
// Stream-to-operand loader for the 4-4-2 network: assembles weight/input frames,
// issues one inference per input frame and waits for both result strobes.
// Optional: define NN_LOADER_FRAME_CHK_EN to enforce s_last framing.
module nn_input_loader
    import nn_loader_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [DW-1:0]      s_data,
    input  logic               s_kind,
    input  logic               s_last,
    output logic [N_X*DW-1:0]  x_bus,
    output logic [N_W*DW-1:0]  w_bus,
    output logic               in_ready,
    input  logic               out0_ready,
    input  logic               out1_ready,
    output logic               busy,
    output logic               w_loaded,
    output logic               err
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t         state, state_nxt;
    logic           xfer, w_last, x_last, cur_last, early, late;
    logic           wr_w, wr_x, clr_w, clr_x, com_w, com_x, set_err, set_wl;
    logic           r0, r1, drain, drain_nxt;
    logic [TW-1:0]  timer;

    nn_frame_shift #(.DEPTH(N_W)) u_w_shift (
        .clk(clk), .rst(rst), .wr_en(wr_w), .wr_data(word_t'(s_data)),
        .clr(clr_w), .commit(com_w), .at_last(w_last), .bus(w_bus)
    );

    nn_frame_shift #(.DEPTH(N_X)) u_x_shift (
        .clk(clk), .rst(rst), .wr_en(wr_x), .wr_data(word_t'(s_data)),
        .clr(clr_x), .commit(com_x), .at_last(x_last), .bus(x_bus)
    );

    assign s_ready  = (state == IDLE) || (state == LOAD_W) || (state == LOAD_X);
    assign in_ready = (state == ISSUE) || (state == WAIT);
    assign busy     = in_ready;
    assign xfer     = s_valid && s_ready;
    assign cur_last = (state == LOAD_W) ? w_last : (state == LOAD_X) ? x_last : 1'b0;

`ifdef NN_LOADER_FRAME_CHK_EN
    assign early = s_last && !cur_last;
    assign late  = !s_last && cur_last;
`else
    // Frames are delimited by count alone; drain never arms in this build.
    assign early = 1'b0;
    assign late  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        wr_w      = 1'b0;
        wr_x      = 1'b0;
        clr_w     = 1'b0;
        clr_x     = 1'b0;
        com_w     = 1'b0;
        com_x     = 1'b0;
        set_err   = 1'b0;
        set_wl    = 1'b0;
        drain_nxt = drain;
        case (state)
            IDLE: if (xfer) begin
                if (drain) begin
                    if (s_last) drain_nxt = 1'b0;
                end else if (early) begin
                    set_err = 1'b1;
                end else if (s_kind) begin
                    wr_w      = 1'b1;
                    state_nxt = LOAD_W;
                end else begin
                    wr_x      = 1'b1;
                    state_nxt = LOAD_X;
                end
            end
            LOAD_W: if (xfer) begin
                if (early || late) begin
                    set_err   = 1'b1;
                    clr_w     = 1'b1;
                    drain_nxt = late;
                    state_nxt = IDLE;
                end else begin
                    wr_w = 1'b1;
                    if (w_last) begin
                        com_w     = 1'b1;
                        clr_w     = 1'b1;
                        set_wl    = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            LOAD_X: if (xfer) begin
                if (early || late) begin
                    set_err   = 1'b1;
                    clr_x     = 1'b1;
                    drain_nxt = late;
                    state_nxt = IDLE;
                end else begin
                    wr_x = 1'b1;
                    if (x_last) begin
                        clr_x     = 1'b1;
                        state_nxt = IDLE;
                        // Inputs without weights are dropped rather than issued.
                        if (w_loaded) begin
                            com_x     = 1'b1;
                            state_nxt = ISSUE;
                        end else begin
                            set_err = 1'b1;
                        end
                    end
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if ((r0 || out0_ready) && (r1 || out1_ready)) begin
                    state_nxt = IDLE;
                end else if (timer == TW'(TIMEOUT-1)) begin
                    set_err   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err      <= 1'b0;
            w_loaded <= 1'b0;
            drain    <= 1'b0;
            r0       <= 1'b0;
            r1       <= 1'b0;
            timer    <= '0;
        end else begin
            drain <= drain_nxt;
            if (set_err) err      <= 1'b1;
            if (set_wl)  w_loaded <= 1'b1;
            if (state == ISSUE) begin
                r0    <= 1'b0;
                r1    <= 1'b0;
                timer <= '0;
            end else if (state == WAIT) begin
                r0    <= r0 | out0_ready;
                r1    <= r1 | out1_ready;
                timer <= timer + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_nn_input_loader.sv
// Self-checking bench for nn_input_loader: vector table of input frames with
// staggered result strobes, scoreboard of committed operands, corner sequences.
module tb_nn_input_loader;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         s_valid = 1'b0, s_ready;
    logic [4:0]   s_data = '0;
    logic         s_kind = 1'b0, s_last = 1'b0;
    logic [19:0]  x_bus;
    logic [139:0] w_bus;
    logic         in_ready, busy, w_loaded, err;
    logic         out0_ready = 1'b0, out1_ready = 1'b0;

    int total = 0;
    int passed = 0;

    typedef struct {
        logic [19:0] x;
        int          d0;
        int          d1;
        int          fall;
    } vec_t;

    typedef struct {
        logic [19:0]  x;
        logic [139:0] w;
    } exp_t;

    exp_t         sb[$];
    vec_t         tbl[5];
    logic [139:0] wexp, wall15, wneg;
    int           wv[28];

    nn_input_loader dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_kind(s_kind), .s_last(s_last),
        .x_bus(x_bus), .w_bus(w_bus), .in_ready(in_ready),
        .out0_ready(out0_ready), .out1_ready(out1_ready),
        .busy(busy), .w_loaded(w_loaded), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic check(input string name, input logic [139:0] act, input logic [139:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else passed++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic send_word(input logic [4:0] d, input logic k, input logic l);
        int n = 0;
        s_valid = 1'b1; s_data = d; s_kind = k; s_last = l;
        while (!s_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("s_ready_wait", 0, 1);
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic send_frame(input logic k, input int n, input logic [139:0] words, input int last_at);
        for (int i = 0; i < n; i++) send_word(words[5*i +: 5], k, i == last_at);
    endtask

    // Sends one input frame, checks the committed operands against the
    // scoreboard, then strobes the results and measures when in_ready drops.
    task automatic run_inference(input logic [19:0] x, input int d0, input int d1, input int exp_fall);
        exp_t e;
        int   fall = -1;
        int   viol = 0;
        sb.push_back('{x: x, w: wexp});
        send_frame(1'b0, 4, {120'b0, x}, 3);
        check("in_ready_latency", in_ready, 1);
        check("busy_issue", busy, 1);
        if (sb.size() == 0) check("sb_empty", 0, 1);
        else begin
            e = sb.pop_front();
            check("x_bus_commit", x_bus, e.x);
            check("w_bus_commit", w_bus, e.w);
        end
        @(posedge clk); #1;
        s_valid = 1'b1; s_data = 5'h0a; s_kind = 1'b0;
        for (int c = 0; c < 100; c++) begin
            out0_ready = (c == d0);
            out1_ready = (c == d1);
            if (s_ready) viol++;
            @(posedge clk); #1;
            if (!in_ready) begin
                fall = c + 1;
                break;
            end
        end
        s_valid = 1'b0; out0_ready = 1'b0; out1_ready = 1'b0;
        check("s_ready_low_in_wait", viol, 0);
        check("in_ready_fall_cycle", fall, exp_fall);
        check("s_ready_after_done", s_ready, 1);
        check("busy_after_done", busy, 0);
        check("err_clean", err, 0);
    endtask

    initial begin
        int c;
        wv = '{3, 2, 13, -6, -9, 1, -4, 14, 3, 6, -15, 15, 9, -10, 15, -10,
               0, -1, 3, -11, -12, -15, -15, 6, 5, -7, 0, 1};
        for (int k = 0; k < 28; k++) begin
            wexp[5*k +: 5]   = 5'(wv[k]);
            wall15[5*k +: 5] = 5'd15;
            wneg[5*k +: 5]   = 5'h10;
        end
        tbl[0] = '{{5'd1, 5'd4, 5'd2, 5'd4},       3, 7, 8};
        tbl[1] = '{{5'h10, 5'h0f, 5'h00, 5'h1f},   5, 5, 6};
        tbl[2] = '{{5'h1e, 5'h01, 5'h18, 5'h07},   0, 2, 3};
        tbl[3] = '{{5'h0b, 5'h00, 5'h1d, 5'h09},   4, 1, 5};
        tbl[4] = '{{5'h03, 5'h1c, 5'h06, 5'h11},   0, 0, 1};

        @(posedge clk); #1;
        do_reset();
        check("rst_s_ready", s_ready, 1);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_w_loaded", w_loaded, 0);
        check("rst_err", err, 0);
        check("rst_x_bus", x_bus, 0);
        check("rst_w_bus", w_bus, 0);

        // Input frame with no weights loaded.
        send_frame(1'b0, 4, {120'b0, 5'd1, 5'd4, 5'd2, 5'd4}, 3);
        check("nowt_err", err, 1);
        check("nowt_in_ready", in_ready, 0);
        repeat (3) @(posedge clk); #1;
        check("nowt_in_ready_later", in_ready, 0);
        check("nowt_x_bus", x_bus, 0);
        check("nowt_s_ready", s_ready, 1);
        do_reset();

        send_frame(1'b1, 28, wexp, 27);
        check("wt_loaded", w_loaded, 1);
        check("wt_w_bus", w_bus, wexp);
        check("wt_x_bus_untouched", x_bus, 0);
        check("wt_in_ready", in_ready, 0);

        for (int i = 0; i < 4; i++) run_inference(tbl[i].x, tbl[i].d0, tbl[i].d1, tbl[i].fall);

        // Timeout: no result strobes at all.
        sb.push_back('{x: 20'h0_1234, w: wexp});
        send_frame(1'b0, 4, {120'b0, 20'h0_1234}, 3);
        begin
            exp_t e;
            e = sb.pop_front();
            check("to_x_bus", x_bus, e.x);
        end
        @(posedge clk); #1;
        c = 0;
        while (busy && c < 200) begin
            @(posedge clk); #1;
            c++;
        end
        check("to_wait_cycles", c, 64);
        check("to_err", err, 1);
        check("to_in_ready", in_ready, 0);
        check("to_s_ready", s_ready, 1);
        do_reset();
        check("to_rst_err", err, 0);

        // Reset in the middle of a weight frame.
        send_frame(1'b1, 28, wexp, 27);
        send_frame(1'b1, 10, wneg, 99);
        check("mid_w_bus_kept", w_bus, wexp);
        check("mid_w_loaded_kept", w_loaded, 1);
        do_reset();
        check("mid_rst_w_bus", w_bus, 0);
        check("mid_rst_w_loaded", w_loaded, 0);
        check("mid_rst_x_bus", x_bus, 0);
        check("mid_rst_s_ready", s_ready, 1);
        send_frame(1'b1, 28, wall15, 27);
        check("all15_w_bus", w_bus, wall15);
        wexp = wall15;
        run_inference({4{5'd15}}, 0, 0, 1);
        run_inference(tbl[4].x, tbl[4].d0, tbl[4].d1, tbl[4].fall);

`ifdef NN_LOADER_FRAME_CHK_EN
        send_frame(1'b1, 21, wneg, 20);
        check("fc_err", err, 1);
        check("fc_w_bus", w_bus, wall15);
        check("fc_s_ready", s_ready, 1);
        check("fc_in_ready", in_ready, 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
